// File: rtl/xorshift_stream_src.sv
// xorshift_stream_src
// Producer end of a 64-bit per-CPU data stream. A start request loads a
// seed and a word count; the block then emits the xorshift64 (13,7,17)
// sequence over a valid/ready interface, flags the final word with
// out_last, and holds done high once the sequence has been accepted.
// All state lives in registers, so every output is glitch-free and
// out_valid never depends combinationally on out_ready.

module xorshift_stream_src #(
    parameter int          CNT_W         = 32,
    parameter logic [63:0] ZERO_SEED_SUB = 64'h8817_2645_4633_2525
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [63:0]      seed,
    input  logic [CNT_W-1:0] num_words,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] words_sent
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [63:0]      data_q, data_n;
    logic             valid_q, valid_n;
    logic             last_q, last_n;
    logic [CNT_W-1:0] remaining_q, remaining_n;
    logic [CNT_W-1:0] sent_q, sent_n;
    logic [63:0]      start_state;
    logic             handshake;

    // One xorshift64 step; shifted-out bits fall off the 64-bit word.
    function automatic logic [63:0] xs(input logic [63:0] x);
        logic [63:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 7);
        return t ^ (t << 17);
    endfunction

    // A zero state would lock xorshift at zero forever, so substitute a
    // fixed non-zero seed when zero is requested.
    assign start_state = (seed == 64'd0) ? ZERO_SEED_SUB : seed;
    assign handshake   = valid_q & out_ready;

    // Next-state logic: launch a sequence on start, advance on each accepted word.
    always_comb begin
        state_n     = state;
        data_n      = data_q;
        valid_n     = valid_q;
        last_n      = last_q;
        remaining_n = remaining_q;
        sent_n      = sent_q;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    sent_n = '0;
                    if (num_words != '0) begin
                        state_n     = RUN;
                        data_n      = xs(start_state);
                        valid_n     = 1'b1;
                        last_n      = (num_words == CNT_W'(1));
                        remaining_n = num_words;
                    end else begin
                        state_n     = DONE;
                        valid_n     = 1'b0;
                        last_n      = 1'b0;
                        remaining_n = '0;
                    end
                end
            end
            RUN: begin
                if (handshake) begin
                    sent_n      = sent_q + CNT_W'(1);
                    remaining_n = remaining_q - CNT_W'(1);
                    if (last_q) begin
                        state_n = DONE;
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                    end else begin
                        data_n = xs(data_q);
                        last_n = (remaining_q == CNT_W'(2));
                    end
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
                last_n  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset drops any pending word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            remaining_q <= '0;
            sent_q      <= '0;
        end else begin
            state       <= state_n;
            data_q      <= data_n;
            valid_q     <= valid_n;
            last_q      <= last_n;
            remaining_q <= remaining_n;
            sent_q      <= sent_n;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_last   = last_q;
    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign words_sent = sent_q;

endmodule

// File: tb/tb_xorshift_stream_src.sv
// tb_xorshift_stream_src
// Directed bench for xorshift_stream_src. Inputs change and outputs are
// sampled on the falling edge, half a cycle away from the active edge.

module tb_xorshift_stream_src;

    localparam int          CNT_W    = 32;
    localparam logic [63:0] ZSUB     = 64'h8817_2645_4633_2525;
    localparam logic [63:0] W0_SEED1 = 64'h0000_0000_4082_2041;

    logic             clk;
    logic             rst;
    logic             start;
    logic [63:0]      seed;
    logic [CNT_W-1:0] num_words;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic             out_last;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] words_sent;

    int total;
    int bad;

    logic [63:0] exp_words [0:7];

    xorshift_stream_src #(.CNT_W(CNT_W), .ZERO_SEED_SUB(ZSUB)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seed       (seed),
        .num_words  (num_words),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .words_sent (words_sent)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference xorshift64 (13,7,17) step.
    function automatic logic [63:0] xs_model(input logic [63:0] x);
        logic [63:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 7);
        return t ^ (t << 17);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Pulse start for one cycle with the given seed and length.
    task automatic applyStimulus(input logic [63:0] s, input logic [CNT_W-1:0] n);
        seed      = s;
        num_words = n;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    initial begin
        int          k;
        logic [63:0] w;
        logic [15:0] ready_pat;

        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        start     = 1'b1;
        seed      = 64'd1;
        num_words = CNT_W'(4);
        out_ready = 1'b1;
        exp_words[0] = W0_SEED1;
        for (int i = 1; i < 8; i++) exp_words[i] = xs_model(exp_words[i-1]);

        // Reset held with start asserted: reset must win.
        step();
        step();
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_data", out_data, 64'd0);
        checkOutput("rst_last", 64'(out_last), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_sent", 64'(words_sent), 64'd0);
        rst   = 1'b0;
        start = 1'b0;
        step();

        // Seed 1, single word.
        applyStimulus(64'd1, CNT_W'(1));
        checkOutput("one_valid", 64'(out_valid), 64'd1);
        checkOutput("one_data", out_data, W0_SEED1);
        checkOutput("one_last", 64'(out_last), 64'd1);
        checkOutput("one_busy", 64'(busy), 64'd1);
        step();
        checkOutput("one_valid_after", 64'(out_valid), 64'd0);
        checkOutput("one_done", 64'(done), 64'd1);
        checkOutput("one_sent", 64'(words_sent), 64'd1);
        checkOutput("one_data_hold", out_data, W0_SEED1);

        // Seed 1, eight words, always ready.
        applyStimulus(64'd1, CNT_W'(8));
        checkOutput("eight_done_dropped", 64'(done), 64'd0);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("eight_valid%0d", i), 64'(out_valid), 64'd1);
            checkOutput($sformatf("eight_data%0d", i), out_data, exp_words[i]);
            checkOutput($sformatf("eight_last%0d", i), 64'(out_last), 64'(i == 7));
            step();
        end
        checkOutput("eight_done", 64'(done), 64'd1);
        checkOutput("eight_valid_end", 64'(out_valid), 64'd0);
        checkOutput("eight_sent", 64'(words_sent), 64'd8);

        // Same sequence with a throttling consumer.
        ready_pat = 16'b1011_0010_1101_0100;
        out_ready = 1'b0;
        applyStimulus(64'd1, CNT_W'(8));
        k = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            out_ready = ready_pat[i % 16];
            if (out_valid) begin
                checkOutput($sformatf("thr_data%0d_c%0d", k, i), out_data, exp_words[k % 8]);
                checkOutput($sformatf("thr_last%0d_c%0d", k, i), 64'(out_last), 64'(k == 7));
                if (out_ready) k++;
            end
            step();
        end
        out_ready = 1'b1;
        checkOutput("thr_accepted", 64'(k), 64'd8);
        checkOutput("thr_done", 64'(done), 64'd1);
        checkOutput("thr_sent", 64'(words_sent), 64'd8);

        // Zero seed falls back to the substitute seed.
        applyStimulus(64'd0, CNT_W'(2));
        w = xs_model(ZSUB);
        checkOutput("zs_data0", out_data, w);
        checkOutput("zs_nonzero0", 64'(out_data != 64'd0), 64'd1);
        checkOutput("zs_last0", 64'(out_last), 64'd0);
        step();
        checkOutput("zs_data1", out_data, xs_model(w));
        checkOutput("zs_last1", 64'(out_last), 64'd1);
        step();
        checkOutput("zs_done", 64'(done), 64'd1);

        // Zero-length request, then a three-word request.
        applyStimulus(64'd1, CNT_W'(0));
        checkOutput("nz_done", 64'(done), 64'd1);
        checkOutput("nz_valid", 64'(out_valid), 64'd0);
        checkOutput("nz_sent", 64'(words_sent), 64'd0);
        step();
        checkOutput("nz_valid_later", 64'(out_valid), 64'd0);
        applyStimulus(64'd1, CNT_W'(3));
        checkOutput("n3_done_dropped", 64'(done), 64'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("n3_data%0d", i), out_data, exp_words[i]);
            checkOutput($sformatf("n3_last%0d", i), 64'(out_last), 64'(i == 2));
            step();
        end
        checkOutput("n3_done", 64'(done), 64'd1);
        checkOutput("n3_sent", 64'(words_sent), 64'd3);

        // Five-word run: accept two, stall, ignore a mid-run start, then reset.
        applyStimulus(64'd1, CNT_W'(5));
        step();
        step();
        out_ready = 1'b0;
        checkOutput("mid_sent2", 64'(words_sent), 64'd2);
        checkOutput("mid_data2", out_data, exp_words[2]);
        applyStimulus(64'hDEAD_BEEF_0000_0001, CNT_W'(1));
        checkOutput("mid_start_busy", 64'(busy), 64'd1);
        checkOutput("mid_start_data", out_data, exp_words[2]);
        checkOutput("mid_start_last", 64'(out_last), 64'd0);
        checkOutput("mid_start_valid", 64'(out_valid), 64'd1);
        checkOutput("mid_start_sent", 64'(words_sent), 64'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("mrst_valid", 64'(out_valid), 64'd0);
        checkOutput("mrst_data", out_data, 64'd0);
        checkOutput("mrst_busy", 64'(busy), 64'd0);
        checkOutput("mrst_done", 64'(done), 64'd0);
        checkOutput("mrst_sent", 64'(words_sent), 64'd0);
        out_ready = 1'b1;
        applyStimulus(64'd1, CNT_W'(5));
        checkOutput("restart_data0", out_data, W0_SEED1);
        checkOutput("restart_valid", 64'(out_valid), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
